// File: rtl/eviction_write_buffer_pkg.sv
// Shared types for the L1 eviction write buffer: line/address types,
// drain state encoding and the default buffer depth.
package eviction_write_buffer_pkg;

   localparam int LC3B_WB_DEPTH    = 4;
   localparam int LC3B_LINE_WIDTH  = 128;
   localparam int LC3B_LADDR_WIDTH = 12;

   typedef logic [LC3B_LADDR_WIDTH-1:0] lc3b_line_addr;
   typedef logic [LC3B_LINE_WIDTH-1:0]  lc3b_line;

   typedef enum logic [0:0] {
      wb_idle  = 1'b0,
      wb_write = 1'b1
   } lc3b_wb_state;

endpackage

// File: rtl/eviction_write_buffer_wb_match.sv
// DEPTH-way line-address comparator. Only valid entries can match, and the
// buffer never holds two valid copies of one line, so the result is one-hot.
module wb_match
   import eviction_write_buffer_pkg::*;
#(
   parameter int DEPTH       = LC3B_WB_DEPTH,
   parameter int LADDR_WIDTH = LC3B_LADDR_WIDTH
) (
   input  logic [DEPTH-1:0]                  valid_i,
   input  logic [DEPTH-1:0][LADDR_WIDTH-1:0] addr_i,
   input  logic [LADDR_WIDTH-1:0]            cmp_addr_i,
   output logic [DEPTH-1:0]                  match_o
);

   // Per-entry valid-qualified address compare.
   always_comb begin
      match_o = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         match_o[i] = valid_i[i] && (addr_i[i] == cmp_addr_i);
      end
   end

endmodule

// File: rtl/eviction_write_buffer.sv
// Write buffer between L1 and L2: queues dirty victim lines, coalesces
// rewrites of a queued line, forwards queued data to L1 misses, and drains
// the oldest line to L2 one write at a time.
module eviction_write_buffer
   import eviction_write_buffer_pkg::*;
#(
   parameter int DEPTH       = LC3B_WB_DEPTH,
   parameter int LINE_WIDTH  = LC3B_LINE_WIDTH,
   parameter int LADDR_WIDTH = LC3B_LADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_write,
   input  logic [LADDR_WIDTH-1:0] in_addr,
   input  logic [LINE_WIDTH-1:0]  in_wdata,
   output logic                   in_resp,
   input  logic [LADDR_WIDTH-1:0] rd_addr,
   output logic                   rd_hit,
   output logic [LINE_WIDTH-1:0]  rd_data,
   output logic                   pmem_write,
   output logic [LADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0]  pmem_wdata,
   input  logic                   pmem_resp,
   output logic                   empty,
   output logic                   full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0]                  valid_q, valid_d;
   logic [DEPTH-1:0][LADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DEPTH-1:0][LINE_WIDTH-1:0]  data_q, data_d;
   logic [PTR_W-1:0]                  head_q, head_d;
   logic [PTR_W-1:0]                  tail_q, tail_d;
   logic [CNT_W-1:0]                  count_q, count_d;
   lc3b_wb_state                      state_q, state_d;
   logic                              in_resp_q, in_resp_d;

   logic [DEPTH-1:0]      in_match_s;
   logic [DEPTH-1:0]      rd_match_s;
   logic [DEPTH-1:0]      entry_we_s;
   logic                  in_hit_s;
   logic                  head_match_s;
   logic                  coalesce_ok_s;
   logic                  push_ok_s;
   logic                  accept_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  full_s;
   logic                  pmem_write_s;
   logic [LINE_WIDTH-1:0] rd_data_s;

   wb_match #(
      .DEPTH       (DEPTH),
      .LADDR_WIDTH (LADDR_WIDTH)
   ) u_in_match (
      .valid_i    (valid_q),
      .addr_i     (addr_q),
      .cmp_addr_i (in_addr),
      .match_o    (in_match_s)
   );

   wb_match #(
      .DEPTH       (DEPTH),
      .LADDR_WIDTH (LADDR_WIDTH)
   ) u_rd_match (
      .valid_i    (valid_q),
      .addr_i     (addr_q),
      .cmp_addr_i (rd_addr),
      .match_o    (rd_match_s)
   );

   // The head line is frozen while L2 is writing it, so a rewrite of it must
   // wait and become a fresh entry; in_resp_q blocks re-accepting a held request.
   assign full_s        = (count_q == CNT_W'(DEPTH));
   assign in_hit_s      = |in_match_s;
   assign head_match_s  = in_match_s[head_q];
   assign coalesce_ok_s = in_hit_s && (!head_match_s || (state_q == wb_idle));
   assign push_ok_s     = !in_hit_s && !full_s;
   assign accept_s      = in_write && !in_resp_q && (coalesce_ok_s || push_ok_s);
   assign push_s        = accept_s && !in_hit_s;
   assign pop_s         = (state_q == wb_write) && pmem_resp;
   assign in_resp_d     = accept_s;

   // Entry write enables: matched entry on coalesce, tail slot on push.
   always_comb begin
      entry_we_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         entry_we_s[i] = accept_s &&
                         ((in_hit_s && in_match_s[i]) ||
                          (!in_hit_s && (tail_q == PTR_W'(i))));
      end
   end

   // Next state of storage, pointers and occupancy count.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_we_s[i]) begin
            valid_d[i] = 1'b1;
            addr_d[i]  = in_addr;
            data_d[i]  = in_wdata;
         end else if (pop_s && (head_q == PTR_W'(i))) begin
            valid_d[i] = 1'b0;
         end else begin
            valid_d[i] = valid_q[i];
         end
      end

      if (push_s) begin
         tail_d = tail_q + PTR_W'(1);
      end else begin
         tail_d = tail_q;
      end

      if (pop_s) begin
         head_d = head_q + PTR_W'(1);
      end else begin
         head_d = head_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage, pointer, count and in_resp registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= {DEPTH{1'b0}};
         addr_q    <= {(DEPTH*LADDR_WIDTH){1'b0}};
         data_q    <= {(DEPTH*LINE_WIDTH){1'b0}};
         head_q    <= {PTR_W{1'b0}};
         tail_q    <= {PTR_W{1'b0}};
         count_q   <= {CNT_W{1'b0}};
         in_resp_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         in_resp_q <= in_resp_d;
      end
   end

   // Drain FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= wb_idle;
      end else begin
         state_q <= state_d;
      end
   end

   // Drain FSM next state; leaving WRITE always passes through IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         wb_idle: begin
            if (count_q != {CNT_W{1'b0}}) begin
               state_d = wb_write;
            end else begin
               state_d = wb_idle;
            end
         end
         wb_write: begin
            if (pmem_resp) begin
               state_d = wb_idle;
            end else begin
               state_d = wb_write;
            end
         end
         default: state_d = wb_idle;
      endcase
   end

   // Drain FSM outputs.
   always_comb begin
      pmem_write_s = 1'b0;
      case (state_q)
         wb_idle:  pmem_write_s = 1'b0;
         wb_write: pmem_write_s = 1'b1;
         default:  pmem_write_s = 1'b0;
      endcase
   end

   // Forwarded miss data; at most one entry matches, so OR-reduction selects it.
   always_comb begin
      rd_data_s = {LINE_WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_match_s[i]) begin
            rd_data_s = rd_data_s | data_q[i];
         end else begin
            rd_data_s = rd_data_s;
         end
      end
   end

   assign in_resp      = in_resp_q;
   assign rd_hit       = |rd_match_s;
   assign rd_data      = rd_data_s;
   assign pmem_write   = pmem_write_s;
   assign pmem_address = addr_q[head_q];
   assign pmem_wdata   = data_q[head_q];
   assign empty        = (count_q == {CNT_W{1'b0}}) && (state_q == wb_idle);
   assign full         = full_s;

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Bench for eviction_write_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the buffer.
module tb_eviction_write_buffer;

   localparam int DEPTH = 4;

   logic         clk;
   logic         rst;
   logic         in_write;
   logic [11:0]  in_addr;
   logic [127:0] in_wdata;
   logic         in_resp;
   logic [11:0]  rd_addr;
   logic         rd_hit;
   logic [127:0] rd_data;
   logic         pmem_write;
   logic [11:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic         pmem_resp;
   logic         empty;
   logic         full;

   eviction_write_buffer #(.DEPTH(DEPTH), .LINE_WIDTH(128), .LADDR_WIDTH(12)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_write     (in_write),
      .in_addr      (in_addr),
      .in_wdata     (in_wdata),
      .in_resp      (in_resp),
      .rd_addr      (rd_addr),
      .rd_hit       (rd_hit),
      .rd_data      (rd_data),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .empty        (empty),
      .full         (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: queue of buffered lines (front = oldest), L2-busy flag,
   // and the in_resp expected this cycle.
   logic [11:0]  m_a[$];
   logic [127:0] m_d[$];
   bit           m_writing;
   bit           m_resp;

   // Requester and L2 stimulus state.
   bit           req_pend;
   bit           just_done;
   logic [11:0]  req_a;
   logic [127:0] req_d;
   logic [11:0]  probe_a;
   int           resp_mode;   // 0: L2 never answers, 1: answers at once, 2: random
   logic [11:0]  log_a[$];
   logic [127:0] log_d[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_a.delete();
      m_d.delete();
      m_writing = 1'b0;
      m_resp    = 1'b0;
      req_pend  = 1'b0;
      just_done = 1'b0;
   endtask

   task automatic check_outputs();
      int idx;
      idx = -1;
      for (int k = 0; k < m_a.size(); k++) if (m_a[k] == rd_addr) idx = k;
      chk("in_resp", in_resp, m_resp);
      chk("pmem_write", pmem_write, m_writing);
      chk("empty", empty, (m_a.size() == 0) && !m_writing);
      chk("full", full, m_a.size() == DEPTH);
      chk("rd_hit", rd_hit, idx >= 0);
      chk("rd_data", rd_data, (idx >= 0) ? m_d[idx] : 128'h0);
      if (m_writing) begin
         chk("pmem_address", pmem_address, m_a[0]);
         chk("pmem_wdata", pmem_wdata, m_d[0]);
      end
   endtask

   // Applies the buffer's rules to the current inputs as the next edge will.
   task automatic model_step();
      int idx;
      int sz;
      bit acc;
      idx = -1;
      acc = 1'b0;
      sz  = m_a.size();
      for (int k = 0; k < sz; k++) if (m_a[k] == in_addr) idx = k;
      if (in_write && !m_resp) begin
         if (idx >= 0) begin
            if (!(idx == 0 && m_writing)) begin
               acc = 1'b1;
               m_d[idx] = in_wdata;
            end
         end else if (sz < DEPTH) begin
            acc = 1'b1;
         end
      end
      if (m_writing && pmem_resp) begin
         void'(m_a.pop_front());
         void'(m_d.pop_front());
      end
      if (acc && idx < 0) begin
         m_a.push_back(in_addr);
         m_d.push_back(in_wdata);
      end
      m_writing = m_writing ? !pmem_resp : (sz > 0);
      m_resp    = acc;
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic tick();
      in_write  = req_pend;
      in_addr   = req_a;
      in_wdata  = req_d;
      rd_addr   = probe_a;
      pmem_resp = m_writing && (resp_mode == 1 || (resp_mode == 2 && $urandom_range(0, 2) == 0));
      #1;
      check_outputs();
      if (pmem_resp) begin
         log_a.push_back(pmem_address);
         log_d.push_back(pmem_wdata);
      end
      just_done = 1'b0;
      if (m_resp) begin
         req_pend  = 1'b0;
         just_done = 1'b1;
      end
      model_step();
      @(negedge clk);
   endtask

   task automatic start_req(input logic [11:0] a, input logic [127:0] d);
      req_pend = 1'b1;
      req_a    = a;
      req_d    = d;
   endtask

   task automatic wait_req();
      for (int k = 0; k < 100 && req_pend; k++) tick();
      chk("req_timeout", req_pend, 1'b0);
   endtask

   task automatic request(input logic [11:0] a, input logic [127:0] d);
      start_req(a, d);
      wait_req();
      tick();
   endtask

   task automatic drain();
      resp_mode = 1;
      for (int k = 0; k < 100 && !(m_a.size() == 0 && !m_writing); k++) tick();
      chk("drain_empty", empty, 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] da, db, dc;
      logic [11:0]  a;
      rst       = 1'b1;
      in_write  = 1'b0;
      in_addr   = 12'h000;
      in_wdata  = 128'h0;
      rd_addr   = 12'h000;
      pmem_resp = 1'b0;
      probe_a   = 12'h000;
      req_a     = 12'h000;
      req_d     = 128'h0;
      resp_mode = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_outputs();
      chk("rst_pmem_address", pmem_address, 12'h000);
      chk("rst_pmem_wdata", pmem_wdata, 128'h0);
      rst = 1'b0;
      @(negedge clk);

      // Single push: forwarded to misses and written to L2.
      da = 128'hA0A0_0000_1111_2222_3333_4444_5555_6666;
      probe_a = 12'h010;
      request(12'h010, da);
      chk("t35_pmem_write", pmem_write, 1'b1);
      chk("t35_pmem_address", pmem_address, 12'h010);
      chk("t35_rd_hit", rd_hit, 1'b1);
      chk("t35_rd_data", rd_data, da);
      drain();

      // Full buffer stalls a new line until a pop frees a slot.
      resp_mode = 0;
      log_a.delete();
      log_d.delete();
      for (int i = 0; i < 4; i++) request(12'h100 + 12'(i) * 12'h010, {4{32'(i + 1)}});
      start_req(12'h050, 128'h5050);
      repeat (4) tick();
      chk("t36_full", full, 1'b1);
      chk("t36_stall", in_resp, 1'b0);
      resp_mode = 1;
      tick();
      resp_mode = 0;
      wait_req();
      tick();
      chk("t36_first_pop", log_a[0], 12'h100);
      chk("t36_rd_hit_050", rd_hit, 1'b0);
      drain();

      // Coalesce into a queued non-head line.
      log_a.delete();
      log_d.delete();
      resp_mode = 0;
      da = 128'hAAAA;
      db = 128'hBBBB;
      dc = 128'hCCCC;
      request(12'h020, da);
      request(12'h030, db);
      request(12'h030, dc);
      drain();
      chk("t37_l2_count", log_a.size(), 2);
      chk("t37_l2_a0", log_a[0], 12'h020);
      chk("t37_l2_d0", log_d[0], da);
      chk("t37_l2_a1", log_a[1], 12'h030);
      chk("t37_l2_d1", log_d[1], dc);

      // Rewrite of the line L2 is writing waits for the pop.
      log_a.delete();
      log_d.delete();
      resp_mode = 0;
      request(12'h020, da);
      start_req(12'h020, db);
      repeat (4) tick();
      chk("t38_stall", in_resp, 1'b0);
      resp_mode = 1;
      wait_req();
      tick();
      drain();
      chk("t38_l2_count", log_a.size(), 2);
      chk("t38_l2_d0", log_d[0], da);
      chk("t38_l2_a1", log_a[1], 12'h020);
      chk("t38_l2_d1", log_d[1], db);

      // Pointer wrap with ten push/drain pairs.
      log_a.delete();
      log_d.delete();
      for (int i = 0; i < 10; i++) begin
         a = 12'h200 + 12'(i) * 12'h010;
         request(a, {4{32'(i + 100)}});
         drain();
      end
      for (int i = 0; i < 10; i++) chk("t39_l2_order", log_a[i], 12'h200 + 12'(i) * 12'h010);
      chk("t39_empty", empty, 1'b1);

      // Random traffic over a small address pool to exercise coalescing.
      resp_mode = 2;
      for (int c = 0; c < 400; c++) begin
         if (!req_pend && !just_done && $urandom_range(0, 1) == 1)
            start_req(12'h040 + 12'($urandom_range(0, 5)) * 12'h010,
                      {$urandom, $urandom, $urandom, $urandom});
         probe_a = 12'h040 + 12'($urandom_range(0, 6)) * 12'h010;
         tick();
      end
      for (int k = 0; k < 100 && req_pend; k++) tick();
      tick();
      drain();

      // Reset in the middle of an L2 write.
      resp_mode = 0;
      request(12'h300, 128'h3);
      request(12'h310, 128'h31);
      chk("t40_pre_write", pmem_write, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("t40_pmem_write", pmem_write, 1'b0);
      chk("t40_empty", empty, 1'b1);
      chk("t40_full", full, 1'b0);
      chk("t40_in_resp", in_resp, 1'b0);
      rd_addr = 12'h300;
      #1;
      chk("t40_rd_hit", rd_hit, 1'b0);
      chk("t40_rd_data", rd_data, 128'h0);
      chk("t40_pmem_address", pmem_address, 12'h000);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      probe_a = 12'h310;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
